cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  - Shares the two Common Data Bus broadcast ports (CDBiscast/CDBiscast2) among N result producers.
//  - Producers are the ALU RS, the branch RS, the load/store unit and a spare slot.
//  - Round-robin, up to two grants per cycle; registered one-cycle broadcast pulses feed all RS and the ROB.
//  - Each port is forced low for one cycle between pulses, so edge-triggered CDB consumers never miss a broadcast.
// PARAMETERS
//  N_REQ     4          number of requesters (2..8)
//  TAG_W     6          ROB tag width
//  DATA_W    32         result data width
// PORTS
//  clock       in   1            system clock, rising edge
//  reset       in   1            asynchronous, active-high
//  flush       in   1            sync mispredict flush; kills grants and pending broadcasts
//  req_valid   in   N_REQ        requester i holds a result
//  req_rob     in   N_REQ*TAG_W  ROB tag of requester i, slice [i*TAG_W +: TAG_W]
//  req_data    in   N_REQ*DATA_W result of requester i, slice [i*DATA_W +: DATA_W]
//  req_ready   out  N_REQ        grant; request consumed when valid&&ready at clock edge
//  CDBiscast   out  1            port 0 broadcast pulse
//  CDBrobNum   out  TAG_W        port 0 tag
//  CDBdata     out  DATA_W       port 0 data
//  CDBiscast2  out  1            port 1 broadcast pulse
//  CDBrobNum2  out  TAG_W        port 1 tag
//  CDBdata2    out  DATA_W       port 1 data
// BEHAVIOUR
//  - Reset values:
//    - CDBiscast=CDBiscast2=0; CDBrobNum=CDBrobNum2=INVALID_TAG (6'b010000); CDBdata=CDBdata2=0.
//    - req_ready=0; rr_ptr=0.
//  - Port state: port p is free in cycle t iff its iscast register was 0 at the end of cycle t-1.
//  - Grant (combinational from registers and inputs):
//    - Scan requesters rr_ptr, rr_ptr+1, ... mod N_REQ.
//    - First valid requester goes to the lowest free port; second valid requester goes to the remaining free port.
//    - At most one grant per free port; req_ready is asserted only for granted requesters.
//    - No grants while flush=1.
//  - Latency: grant at edge t -> iscast=1, tag and data registered at t+1 -> iscast forced 0 at t+2.
//    - Per-port throughput is one broadcast every 2 cycles; aggregate is 1/cycle with two ports.
//  - rr_ptr update: after any grant, rr_ptr = (index of last granted requester + 1) mod N_REQ; unchanged otherwise.
//  - Tag INVALID_TAG: request is granted and consumed, but no broadcast is made (port stays 0 and remains free).
//  - Simultaneous events:
//    - flush and a pending broadcast in the same cycle: iscast registers clear to 0 and no pulse is issued.
//    - rr_ptr is preserved across flush.
//  - A requester dropping valid without ready is legal; nothing is latched for it.
//  - Reset mid-broadcast: outputs return to reset values immediately (async).
//  - Tag/data outputs hold their last values while iscast=0; consumers must qualify with iscast.
// CONFIGURATION
//  CDB_DUAL_EN defined:
//    - both ports are active as described above.
//  CDB_DUAL_EN undefined:
//    - only port 0 grants; at most one grant per cycle.
//    - CDBiscast2 is tied 0; CDBrobNum2=INVALID_TAG; CDBdata2=0.
// STRUCTURE
//  - cdb_pkg: TAG_W, DATA_W, INVALID_TAG=6'b010000, and the function rr_next(idx, n).
//  - Sub-module rr_pick2: combinational picker.
//    - Inputs: valid vector, rr_ptr, free0, free1.
//    - Outputs: first/second grant indices plus hit flags.
//  - cdb_arbiter holds rr_ptr, the port registers and the flush gating.
// TESTING
//  - Reset -> all iscast=0, tags=6'b010000, req_ready=0, rr_ptr=0.
//  - Single request: req0 valid, rob=5, data=0x1234.
//    - Cycle t: ready0=1.
//    - Cycle t+1: CDBiscast=1, CDBrobNum=5, CDBdata=0x1234.
//    - Cycle t+2: CDBiscast=0.
//  - All 4 requests valid and held, rr_ptr=0:
//    - Grants go to {0,1} at t, none at t+1 (both ports cooling), then {2,3} at t+2.
//    - After t+2, rr_ptr=0.
//  - Request 2 with tag 6'b010000 -> ready2=1, no iscast pulse; next valid request is broadcast on the port the next cycle.
//  - flush asserted the cycle after grants to {1,2} -> no iscast pulse; after flush, next grant starts from rr_ptr=3.
//  - CDB_DUAL_EN undefined with 3 requests held -> one grant every 2 cycles in order 0,1,2; CDBiscast2 is never 1.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared constants and helpers for the Common Data Bus arbiter.
package cdb_pkg;

  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;

  // Tag value meaning "consume the result but do not broadcast it".
  localparam logic [TAG_W-1:0] INVALID_TAG = 6'b010000;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester and CDB broadcast signals for cdb_arbiter.
interface cdb_arbiter_if import cdb_pkg::*; #(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = cdb_pkg::TAG_W,
  parameter int DATA_W = cdb_pkg::DATA_W
);

  // Handshake: requester i drives req_valid[i] with its tag/data slice held
  // stable; the result is consumed at the rising edge where req_valid[i] and
  // req_ready[i] are both 1. Valid may drop without ready. req_ready is
  // combinational and only ever asserted for a valid requester.
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*TAG_W-1:0]  req_rob;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;

  logic                    CDBiscast;
  logic [TAG_W-1:0]        CDBrobNum;
  logic [DATA_W-1:0]       CDBdata;
  logic                    CDBiscast2;
  logic [TAG_W-1:0]        CDBrobNum2;
  logic [DATA_W-1:0]       CDBdata2;

  modport master (
    input  req_valid, req_rob, req_data,
    output req_ready,
    output CDBiscast, CDBrobNum, CDBdata,
    output CDBiscast2, CDBrobNum2, CDBdata2
  );

  modport slave (
    output req_valid, req_rob, req_data,
    input  req_ready,
    input  CDBiscast, CDBrobNum, CDBdata,
    input  CDBiscast2, CDBrobNum2, CDBdata2
  );

endinterface

// File: rtl/cdb_arbiter_rr_pick2.sv
// Round-robin picker: up to two valid requesters, scanned from rr_ptr.
module rr_pick2 import cdb_pkg::*; #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         valid,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  input  logic                     free0,
  input  logic                     free1,
  output logic [$clog2(N_REQ)-1:0] first_idx,
  output logic                     first_hit,
  output logic [$clog2(N_REQ)-1:0] second_idx,
  output logic                     second_hit
);

  localparam int IDX_W = $clog2(N_REQ);

  always_comb begin
    int                 j;
    logic [IDX_W-1:0]   jj;
    first_idx  = '0;
    first_hit  = 1'b0;
    second_idx = '0;
    second_hit = 1'b0;
    j          = 0;
    jj         = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      jj = IDX_W'(j);
      if (valid[jj]) begin
        // A second grant needs both ports free; a first needs either one.
        if (!first_hit && (free0 || free1)) begin
          first_hit = 1'b1;
          first_idx = jj;
        end else if (first_hit && !second_hit && free0 && free1) begin
          second_hit = 1'b1;
          second_idx = jj;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin sharing of the two broadcast ports among N_REQ
// producers. Define CDB_DUAL_EN to enable port 1; otherwise only port 0 grants.
module cdb_arbiter import cdb_pkg::*; #(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = cdb_pkg::TAG_W,
  parameter int DATA_W = cdb_pkg::DATA_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  cdb_arbiter_if.master            bus,
  output logic [$clog2(N_REQ)-1:0] rr_ptr
);

  localparam int IDX_W = $clog2(N_REQ);
`ifdef CDB_DUAL_EN
  localparam int N_PORT = 2;
`else
  localparam int N_PORT = 1;
`endif
  localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(INVALID_TAG);

  logic [N_PORT-1:0] iscast_q;
  logic [TAG_W-1:0]  rob_q  [N_PORT];
  logic [DATA_W-1:0] data_q [N_PORT];

  logic [TAG_W-1:0]  rob_in  [N_REQ];
  logic [DATA_W-1:0] data_in [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      rob_in[i]  = bus.req_rob[i*TAG_W +: TAG_W];
      data_in[i] = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  // Flush suppresses every grant in its cycle.
  logic [N_REQ-1:0] valid_g;
  assign valid_g = flush ? '0 : bus.req_valid;

  // A port that pulsed last cycle cools down for one cycle.
  logic free0, free1;
  assign free0 = ~iscast_q[0];
`ifdef CDB_DUAL_EN
  assign free1 = ~iscast_q[1];
`else
  assign free1 = 1'b0;
`endif

  logic [IDX_W-1:0] first_idx, second_idx;
  logic             first_hit, second_hit;

  rr_pick2 #(.N_REQ(N_REQ)) u_pick (
    .valid      (valid_g),
    .rr_ptr     (rr_ptr),
    .free0      (free0),
    .free1      (free1),
    .first_idx  (first_idx),
    .first_hit  (first_hit),
    .second_idx (second_idx),
    .second_hit (second_hit)
  );

  // First pick takes the lowest free port; the second takes port 1.
  logic [N_PORT-1:0] g_hit;
  logic [IDX_W-1:0]  g_idx [N_PORT];

  always_comb begin
    g_hit    = '0;
    g_idx[0] = first_idx;
    g_hit[0] = first_hit && free0;
`ifdef CDB_DUAL_EN
    g_hit[1] = (first_hit && !free0) || second_hit;
    g_idx[1] = free0 ? second_idx : first_idx;
`endif
  end

  always_comb begin
    bus.req_ready = '0;
    for (int p = 0; p < N_PORT; p++) begin
      if (g_hit[p]) bus.req_ready[g_idx[p]] = 1'b1;
    end
  end

  logic [IDX_W-1:0] last_idx;
  assign last_idx = second_hit ? second_idx : first_idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      iscast_q <= '0;
      rr_ptr   <= '0;
      for (int p = 0; p < N_PORT; p++) begin
        rob_q[p]  <= NO_TAG;
        data_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < N_PORT; p++) begin
        iscast_q[p] <= 1'b0;
        // Invalid-tag results are consumed silently; the port stays free.
        if (g_hit[p] && (rob_in[g_idx[p]] != NO_TAG)) begin
          iscast_q[p] <= 1'b1;
          rob_q[p]    <= rob_in[g_idx[p]];
          data_q[p]   <= data_in[g_idx[p]];
        end
      end
      if (first_hit) rr_ptr <= IDX_W'(rr_next(int'(last_idx), N_REQ));
    end
  end

  // A pulse already registered is still cancelled by a flush in its cycle.
  assign bus.CDBiscast = iscast_q[0] & ~flush;
  assign bus.CDBrobNum = rob_q[0];
  assign bus.CDBdata   = data_q[0];
`ifdef CDB_DUAL_EN
  assign bus.CDBiscast2 = iscast_q[1] & ~flush;
  assign bus.CDBrobNum2 = rob_q[1];
  assign bus.CDBdata2   = data_q[1];
`else
  assign bus.CDBiscast2 = 1'b0;
  assign bus.CDBrobNum2 = NO_TAG;
  assign bus.CDBdata2   = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter against a queue-based reference model.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int N = 4;
`ifdef CDB_DUAL_EN
  localparam int NP = 2;
`else
  localparam int NP = 1;
`endif

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset;
  logic       flush;
  logic [1:0] rr_ptr;

  always #5 clock = ~clock;

  cdb_arbiter_if #(.N_REQ(N)) bus ();

  cdb_arbiter #(.N_REQ(N)) dut (
    .clock  (clock),
    .reset  (reset),
    .flush  (flush),
    .bus    (bus),
    .rr_ptr (rr_ptr)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_cast [2];
  logic [5:0]  m_rob  [2];
  logic [31:0] m_data [2];
  int          m_rr;

  // One pending result per requester.
  bit          pv   [N];
  logic [5:0]  prob [N];
  logic [31:0] pdat [N];

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_cast[p] = 1'b0;
      m_rob[p]  = INVALID_TAG;
      m_data[p] = '0;
    end
    m_rr = 0;
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input bit fl, input string tag);
    int         vq[$];
    int         fq[$];
    int         ng;
    logic [N-1:0] exp_ready;
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]           = pv[i];
      bus.req_rob[i*6 +: 6]      = prob[i];
      bus.req_data[i*32 +: 32]   = pdat[i];
    end
    flush = fl;
    #1;
    if (!fl) begin
      for (int p = 0; p < NP; p++) if (!m_cast[p]) fq.push_back(p);
      for (int k = 0; k < N; k++) if (pv[(m_rr + k) % N]) vq.push_back((m_rr + k) % N);
    end
    ng = (fq.size() < vq.size()) ? fq.size() : vq.size();
    exp_ready = '0;
    for (int j = 0; j < ng; j++) exp_ready[vq[j]] = 1'b1;
    check({tag, ".ready"}, bus.req_ready, exp_ready);
    check({tag, ".cast0"}, bus.CDBiscast, m_cast[0] && !fl);
    check({tag, ".rob0"}, bus.CDBrobNum, m_rob[0]);
    check({tag, ".data0"}, bus.CDBdata, m_data[0]);
    check({tag, ".cast1"}, bus.CDBiscast2, m_cast[1] && !fl);
    check({tag, ".rob1"}, bus.CDBrobNum2, m_rob[1]);
    check({tag, ".data1"}, bus.CDBdata2, m_data[1]);
    check({tag, ".rr"}, rr_ptr, m_rr);
    @(posedge clock);
    if (!reset) begin
      m_cast[0] = 1'b0;
      m_cast[1] = 1'b0;
      for (int j = 0; j < ng; j++) begin
        if (prob[vq[j]] != INVALID_TAG) begin
          m_cast[fq[j]] = 1'b1;
          m_rob[fq[j]]  = prob[vq[j]];
          m_data[fq[j]] = pdat[vq[j]];
        end
        pv[vq[j]] = 1'b0;
      end
      if (ng > 0) m_rr = (vq[ng-1] + 1) % N;
    end
    @(negedge clock);
  endtask

  task automatic put(input int i, input logic [5:0] rob, input logic [31:0] dat);
    pv[i]   = 1'b1;
    prob[i] = rob;
    pdat[i] = dat;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bus.req_valid = '0;
    bus.req_rob   = '0;
    bus.req_data  = '0;
    for (int i = 0; i < N; i++) begin
      prob[i] = '0;
      pdat[i] = '0;
    end
    model_reset();
    @(negedge clock);
    step(1'b0, "reset");
    reset = 1'b0;

    // Single request: ready in t, pulse in t+1, low in t+2.
    put(0, 6'd5, 32'h1234);
    step(1'b0, "single_t");
    #1;
    check("single_pulse", bus.CDBiscast, 1'b1);
    check("single_rob", bus.CDBrobNum, 6'd5);
    check("single_data", bus.CDBdata, 32'h1234);
    // Asynchronous reset while the pulse is on the bus.
    #1 reset = 1'b1;
    #1;
    check("midrst_cast", bus.CDBiscast, 1'b0);
    check("midrst_rob", bus.CDBrobNum, INVALID_TAG);
    check("midrst_data", bus.CDBdata, 32'h0);
    check("midrst_rr", rr_ptr, 2'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    put(0, 6'd5, 32'h1234);
    step(1'b0, "single2_t");
    step(1'b0, "single2_t1");
    step(1'b0, "single2_t2");

    // All four requesters valid from rr_ptr=0.
    do_reset();
    for (int i = 0; i < N; i++) put(i, 6'(i + 8), 32'hA000 + i);
    for (int c = 0; c < 6; c++) step(1'b0, "all4");
    step(1'b0, "idle");

    // Invalid tag consumed without a pulse, then a normal request.
    do_reset();
    put(2, INVALID_TAG, 32'hDEAD);
    step(1'b0, "inv_t");
    #1;
    check("inv_nopulse", bus.CDBiscast, 1'b0);
    put(3, 6'd9, 32'h0BEE);
    step(1'b0, "inv_t1");
    step(1'b0, "inv_t2");
    step(1'b0, "inv_t3");

    // Flush the cycle after grants to requesters 1 and 2.
    do_reset();
    put(0, 6'd1, 32'h1);
    step(1'b0, "fl_a");
    step(1'b0, "fl_b");
    put(1, 6'd2, 32'h2);
    put(2, 6'd3, 32'h3);
    step(1'b0, "fl_grant");
    step(1'b1, "fl_flush");
    check("fl_rr", rr_ptr, (NP == 2) ? 2'd3 : 2'd2);
    put(3, 6'd4, 32'h4);
    put(0, 6'd5, 32'h5);
    for (int c = 0; c < 5; c++) step(1'b0, "fl_after");

    // Randomized traffic with withdrawals, invalid tags and flushes.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 1) == 1)
          put(i, ($urandom_range(0, 7) == 0) ? INVALID_TAG : 6'($urandom), $urandom);
        else if (pv[i] && $urandom_range(0, 15) == 0)
          pv[i] = 1'b0;
      end
      step($urandom_range(0, 15) == 0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
